// File: rtl/ram_port_sequencer.sv
// In-order request sequencer for one RAM port: request FIFO, credit-gated read
// issue, fixed-latency read return pipeline and a show-ahead response FIFO.
module ram_port_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_DEPTH = 16,
    parameter int READ_LATENCY  = 1,
    parameter int REQ_DEPTH     = 4,
    parameter int RSP_DEPTH     = 4,
    localparam int AW = $clog2(ADDRESS_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [AW-1:0]         i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [AW-1:0]         o_rsp_addr,
    output logic                  o_ram_en,
    output logic                  o_ram_we,
    output logic [AW-1:0]         o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_din,
    input  logic [DATA_WIDTH-1:0] i_ram_dout,
    output logic                  o_busy
);

    // Handshakes: a transfer happens at a rising edge where valid && ready are
    // both high; valid/payload are held by the source until that edge.
    localparam int QW = $clog2(REQ_DEPTH);
    localparam int RQ = $clog2(RSP_DEPTH);
    localparam int PS = READ_LATENCY + 1;
    localparam int OW = $clog2(RSP_DEPTH + PS + 1) + 1;

    // ---------------- request FIFO ----------------
    logic [QW:0]           req_wr_ptr, req_rd_ptr;
    logic                  req_we_mem   [REQ_DEPTH];
    logic [AW-1:0]         req_addr_mem [REQ_DEPTH];
    logic [DATA_WIDTH-1:0] req_data_mem [REQ_DEPTH];
    logic                  req_empty, req_full, req_push, req_pop, req_write;

    assign req_empty   = (req_wr_ptr == req_rd_ptr);
    assign req_full    = (req_wr_ptr[QW] != req_rd_ptr[QW]) &&
                         (req_wr_ptr[QW-1:0] == req_rd_ptr[QW-1:0]);
    assign o_req_ready = !req_full;
    assign req_push    = i_req_valid && o_req_ready;

    // ---------------- issue decision ----------------
    logic                  head_valid, head_we, issue;
    logic [AW-1:0]         head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic [OW-1:0]         outstanding;
    logic [PS-1:0]         pipe_vld;
    logic [AW-1:0]         pipe_addr [PS];
    logic [RQ:0]           rsp_wr_ptr, rsp_rd_ptr, rsp_count;
    logic                  rsp_empty, rsp_full, rsp_push, rsp_pop;

    // An empty FIFO lets the incoming request go straight to the issue stage.
    assign head_valid = !req_empty || req_push;
    assign head_we    = req_empty ? i_req_we   : req_we_mem[req_rd_ptr[QW-1:0]];
    assign head_addr  = req_empty ? i_req_addr : req_addr_mem[req_rd_ptr[QW-1:0]];
    assign head_data  = req_empty ? i_req_data : req_data_mem[req_rd_ptr[QW-1:0]];

    always_comb begin
        outstanding = OW'(rsp_count);
        for (int i = 0; i < PS; i++) begin
            outstanding = outstanding + OW'(pipe_vld[i]);
        end
        outstanding = outstanding - OW'(rsp_pop);
    end

    assign issue     = head_valid && (head_we || (outstanding < OW'(RSP_DEPTH)));
    assign req_pop   = issue && !req_empty;
    assign req_write = req_push && !(issue && req_empty);

    always_ff @(posedge i_clk) begin
        if (req_write) begin
            req_we_mem[req_wr_ptr[QW-1:0]]   <= i_req_we;
            req_addr_mem[req_wr_ptr[QW-1:0]] <= i_req_addr;
            req_data_mem[req_wr_ptr[QW-1:0]] <= i_req_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_wr_ptr <= '0;
            req_rd_ptr <= '0;
        end else begin
            if (req_write) req_wr_ptr <= req_wr_ptr + (QW+1)'(1);
            if (req_pop)   req_rd_ptr <= req_rd_ptr + (QW+1)'(1);
        end
    end

    // ---------------- registered RAM port ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ram_en   <= 1'b0;
            o_ram_we   <= 1'b0;
            o_ram_addr <= '0;
            o_ram_din  <= '0;
        end else begin
            o_ram_en   <= issue;
            o_ram_we   <= issue && head_we;
            o_ram_addr <= issue ? head_addr : '0;
            o_ram_din  <= (issue && head_we) ? head_data : '0;
        end
    end

    // ---------------- read return pipeline ----------------
    // Stage 0 mirrors a read on the RAM port; the last stage lines up with valid dout.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < PS; i++) pipe_addr[i] <= '0;
        end else begin
            pipe_vld[0]  <= issue && !head_we;
            pipe_addr[0] <= head_addr;
            for (int i = 1; i < PS; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    // ---------------- response FIFO ----------------
    logic [DATA_WIDTH-1:0] rsp_data_mem [RSP_DEPTH];
    logic [AW-1:0]         rsp_addr_mem [RSP_DEPTH];

    assign rsp_count = rsp_wr_ptr - rsp_rd_ptr;
    assign rsp_empty = (rsp_wr_ptr == rsp_rd_ptr);
    assign rsp_full  = (rsp_wr_ptr[RQ] != rsp_rd_ptr[RQ]) &&
                       (rsp_wr_ptr[RQ-1:0] == rsp_rd_ptr[RQ-1:0]);
    assign rsp_push  = pipe_vld[PS-1];
    assign rsp_pop   = i_rsp_ready && !rsp_empty;

    always_ff @(posedge i_clk) begin
        if (rsp_push) begin
            rsp_data_mem[rsp_wr_ptr[RQ-1:0]] <= i_ram_dout;
            rsp_addr_mem[rsp_wr_ptr[RQ-1:0]] <= pipe_addr[PS-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
        end else begin
            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + (RQ+1)'(1);
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + (RQ+1)'(1);
        end
    end

    assign o_rsp_valid = !rsp_empty;
    assign o_rsp_data  = rsp_empty ? '0 : rsp_data_mem[rsp_rd_ptr[RQ-1:0]];
    assign o_rsp_addr  = rsp_empty ? '0 : rsp_addr_mem[rsp_rd_ptr[RQ-1:0]];
    assign o_busy      = !req_empty || (|pipe_vld) || !rsp_empty || o_ram_en;

    // Read credits cap outstanding reads at RSP_DEPTH, so a push never meets a full FIFO.
    a_rsp_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(rsp_push && rsp_full && !rsp_pop));

endmodule

// File: tb/tb_ram_port_sequencer.sv
// Bench for ram_port_sequencer with a READ_LATENCY=1 RAM model and a response
// scoreboard fed from a reference memory updated in request order.
module tb_ram_port_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [7:0]  req_data = '0;
    logic        rsp_ready = 1'b0;
    logic        o_req_ready, o_rsp_valid, o_ram_en, o_ram_we, o_busy;
    logic [7:0]  o_rsp_data, o_ram_din;
    logic [3:0]  o_rsp_addr, o_ram_addr;
    logic [7:0]  ram_dout = '0;
    logic [7:0]  ram_mem [16] = '{default: 8'h00};
    logic [7:0]  ref_mem [16] = '{default: 8'h00};

    logic [11:0] exp_q[$];
    logic [11:0] exp_v;
    int checks = 0, failures = 0;
    int rd_issue_cnt = 0, rsp_cnt = 0, req_timeouts = 0;

    always #5 clk = ~clk;

    ram_port_sequencer dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(o_req_ready),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_addr(o_rsp_addr),
        .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
        .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din),
        .i_ram_dout(ram_dout), .o_busy(o_busy)
    );

    // Single-port RAM, one cycle read latency.
    always @(posedge clk) begin
        if (o_ram_en) begin
            if (o_ram_we) ram_mem[o_ram_addr] <= o_ram_din;
            else          ram_dout <= ram_mem[o_ram_addr];
        end
    end

    // Scoreboard: every accepted response is matched against the queue head.
    always @(negedge clk) begin
        if (o_ram_en && !o_ram_we) rd_issue_cnt++;
        if (!rst && o_rsp_valid && rsp_ready) begin
            checks++;
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: got addr=%0d data=%h, required no response", o_rsp_addr, o_rsp_data);
            end else begin
                exp_v = exp_q.pop_front();
                if ({o_rsp_addr, o_rsp_data} !== exp_v) begin
                    failures++;
                    $display("FAIL rsp_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             o_rsp_addr, o_rsp_data, exp_v[11:8], exp_v[7:0]);
                end
            end
        end
    end

    task automatic send_req(input logic we, input logic [3:0] addr, input logic [7:0] data);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_data = data;
        @(negedge clk);
        while (!o_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_req_ready) req_timeouts++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (we) ref_mem[addr] = data;
        else    exp_q.push_back({addr, ref_mem[addr]});
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [27:0] outs;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        outs = {o_ram_en, o_ram_we, o_ram_addr, o_ram_din, o_rsp_valid, o_rsp_data, o_rsp_addr, o_busy};
        checks++;
        if (outs !== 28'h0) begin failures++; $display("FAIL reset_outputs: got %h, required 0", outs); end
        checks++;
        if (o_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b, required 1", o_req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd15; req_data = 8'h5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ram_en !== 1'b1) begin failures++; $display("FAIL reset_pre_en: got %b, required 1", o_ram_en); end
        #2 rst = 1'b1;
        #1;
        outs = {o_ram_en, o_ram_we, o_ram_addr, o_ram_din, o_rsp_valid, o_rsp_data, o_rsp_addr, o_busy};
        checks++;
        if (outs !== 28'h0 || o_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_async: got outs=%h ready=%b, required outs=0 ready=1", outs, o_req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        outs = {o_ram_en, o_ram_we, o_ram_addr, o_ram_din, o_rsp_valid, o_rsp_data, o_rsp_addr, o_busy};
        checks++;
        if (outs !== 28'h0 || o_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_idle: got outs=%h ready=%b, required outs=0 ready=1", outs, o_req_ready);
        end
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_data = 8'hA5;
        @(negedge clk);
        checks++;
        if (o_ram_en !== 1'b0) begin failures++; $display("FAIL wr_rd_c_en: got %b, required 0", o_ram_en); end
        @(posedge clk); #1;
        req_we = 1'b0; req_data = 8'h00;
        ref_mem[3] = 8'hA5;
        exp_q.push_back({4'd3, 8'hA5});
        @(negedge clk);
        checks++;
        if ({o_ram_en, o_ram_we, o_ram_addr, o_ram_din} !== {1'b1, 1'b1, 4'd3, 8'hA5}) begin
            failures++;
            $display("FAIL wr_rd_c1_port: got en=%b we=%b addr=%0d din=%h, required 1 1 3 a5", o_ram_en, o_ram_we, o_ram_addr, o_ram_din);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_ram_en, o_ram_we, o_ram_addr, o_ram_din} !== {1'b1, 1'b0, 4'd3, 8'h00}) begin
            failures++;
            $display("FAIL wr_rd_c2_port: got en=%b we=%b addr=%0d din=%h, required 1 0 3 00", o_ram_en, o_ram_we, o_ram_addr, o_ram_din);
        end
        @(negedge clk);
        checks++;
        if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_rd_c3_valid: got %b, required 0", o_rsp_valid); end
        @(negedge clk);
        checks++;
        if ({o_rsp_valid, o_rsp_data, o_rsp_addr} !== {1'b1, 8'hA5, 4'd3}) begin
            failures++;
            $display("FAIL wr_rd_c4_rsp: got valid=%b data=%h addr=%0d, required 1 a5 3", o_rsp_valid, o_rsp_data, o_rsp_addr);
        end
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL wr_rd_drain: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_stream_writes();
        logic [16:0] en_bits = '0;
        int drops = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 4'(i); req_data = 8'(i + 8'h10);
            ref_mem[i] = 8'(i + 8'h10);
            @(negedge clk);
            en_bits[i] = o_ram_en;
            if (!o_req_ready) drops++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        en_bits[16] = o_ram_en;
        checks++;
        if (drops != 0) begin failures++; $display("FAIL stream_ready: got %0d drops, required 0", drops); end
        checks++;
        if (en_bits !== 17'h1FFFE) begin failures++; $display("FAIL stream_en: got %h, required 1fffe", en_bits); end
        @(negedge clk);
        checks++;
        if (o_ram_en !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL stream_idle: got en=%b busy=%b, required 0 0", o_ram_en, o_busy);
        end
    endtask

    task automatic test_credit_backpressure();
        int base_iss, base_rsp, base_to;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        base_iss = rd_issue_cnt; base_rsp = rsp_cnt; base_to = req_timeouts;
        for (int i = 0; i < 8; i++) send_req(1'b0, 4'(i), 8'h00);
        repeat (4) @(negedge clk);
        checks++;
        if (rd_issue_cnt - base_iss != 4) begin failures++; $display("FAIL credit_issued: got %0d, required 4", rd_issue_cnt - base_iss); end
        checks++;
        if (o_req_ready !== 1'b0) begin failures++; $display("FAIL credit_ready_low: got %b, required 0", o_req_ready); end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_drain();
        checks++;
        if (exp_q.size() != 0 || rsp_cnt - base_rsp != 8) begin
            failures++;
            $display("FAIL credit_drain: got %0d responses %0d left, required 8 and 0", rsp_cnt - base_rsp, exp_q.size());
        end
        checks++;
        if (rd_issue_cnt - base_iss != 8 || o_busy !== 1'b0 || o_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL credit_final: got issued=%0d busy=%b ready=%b, required 8 0 1", rd_issue_cnt - base_iss, o_busy, o_req_ready);
        end
        checks++;
        if (req_timeouts != base_to) begin failures++; $display("FAIL credit_req_timeout: got %0d, required 0", req_timeouts - base_to); end
    endtask

    task automatic test_rw_order();
        int base_rsp = rsp_cnt;
        send_req(1'b1, 4'd5, 8'h11);
        send_req(1'b0, 4'd5, 8'h00);
        send_req(1'b1, 4'd5, 8'h3C);
        send_req(1'b0, 4'd5, 8'h00);
        wait_drain();
        checks++;
        if (exp_q.size() != 0 || rsp_cnt - base_rsp != 2) begin
            failures++;
            $display("FAIL rw_order_count: got %0d responses %0d left, required 2 and 0", rsp_cnt - base_rsp, exp_q.size());
        end
    endtask

    task automatic test_reset_inflight();
        int viol = 0;
        int base_iss, base_rsp;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send_req(1'b0, 4'd0, 8'h00);
        send_req(1'b0, 4'd1, 8'h00);
        send_req(1'b0, 4'd2, 8'h00);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (o_rsp_valid) viol++;
        end
        checks++;
        if (viol != 0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL inflight_discard: got %0d valid cycles busy=%b, required 0 0", viol, o_busy);
        end
        @(posedge clk); #1;
        base_iss = rd_issue_cnt; base_rsp = rsp_cnt;
        for (int i = 8; i < 12; i++) send_req(1'b0, 4'(i), 8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (rd_issue_cnt - base_iss != 4 || o_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL inflight_credits: got issued=%0d ready=%b, required 4 1", rd_issue_cnt - base_iss, o_req_ready);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_drain();
        checks++;
        if (exp_q.size() != 0 || rsp_cnt - base_rsp != 4) begin
            failures++;
            $display("FAIL inflight_drain: got %0d responses %0d left, required 4 and 0", rsp_cnt - base_rsp, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_stream_writes();
        test_credit_backpressure();
        test_rw_order();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
